// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two TX FIFO through a valid/ready byte port.
// Frame = start, DATA_BITS LSB first, optional parity, STOP_BITS stop; tick only qualifies the bit timers.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t                 state, state_d;
  logic [TW-1:0]          tick_cnt, tick_cnt_d;
  logic [3:0]             bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic                   par, par_d;
  logic                   txd_d;
  logic                   bit_end;
  logic                   load;
  logic                   push, pop;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;

  assign in_ready = (fifo_count < FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      par      <= par_d;
      txd      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_d      = par;
    pop        = 1'b0;
    tx_done    = 1'b0;
    load       = 1'b0;
    txd_d      = 1'b1;
    bit_end    = tick && (tick_cnt == LAST_TICK);

    if (state != ST_IDLE && tick) tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      ST_IDLE:   ;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            tx_done   = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    // Popping straight out of the last stop tick gives gapless back-to-back frames.
    load = (state == ST_IDLE || tx_done) && (fifo_count != '0);
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      shreg_d    = mem[rd_ptr];
      par_d      = (^mem[rd_ptr]) ^ (PARITY == 1);
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    // txd is registered from the next state so the line changes on the transition edge.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO and a valid/ready byte input. It generalises the team's single-byte reply transmitter in four ways: configurable data width, optional parity, 1 or 2 stop bits, and queued back-to-back frames. It sits between the command/reply logic and the Bluetooth module TXD pin. Timing comes from the shared oversampling baud-tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, number of tick pulses per UART bit; minimum 2.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
tick  in  1  baud×OVERSAMPLE enable; single-clk pulse, synchronous to clk (not a clock)
in_data  in  DATA_BITS  byte to send
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a word
txd  out  1  serial line, idle high, registered
busy  out  1  a frame is in progress or the FIFO is non-empty
tx_done  out  1  one-clk pulse at the end of each frame's last stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Everything is clocked on clk. No logic is clocked by tick; tick only qualifies counters.
- Reset (rst = 0, asynchronous):
  - txd = 1, tx_done = 0, busy = 0, fifo_count = 0, in_ready = 1.
  - FSM goes to IDLE and the FIFO pointers clear.
  - Reset mid-frame aborts the frame immediately: txd returns high with no glitch low, and queued data is discarded.
- FIFO:
  - A push occurs on a clk edge when in_valid && in_ready.
  - in_ready = (fifo_count < FIFO_DEPTH). It is derived from occupancy only, so a same-cycle pop does not allow a push when full.
  - A pop occurs only when the FSM leaves IDLE or STOP for START.
  - Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd = 1. If FIFO is non-empty, pop into the shift register, clear the tick and bit counters, and go to START.
  - START: txd = 0 for OVERSAMPLE ticks, then go to DATA.
  - DATA: send DATA_BITS bits LSB first, each held for OVERSAMPLE ticks.
    - After the last bit, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: hold the parity bit for OVERSAMPLE ticks.
    - Even parity: txd = XOR of the data bits.
    - Odd parity: txd = the inverse of that XOR.
  - STOP: txd = 1 for STOP_BITS×OVERSAMPLE ticks.
    - On the tick that ends STOP, pulse tx_done for one clk.
    - In that same cycle, go to START with a pop if the FIFO is non-empty, otherwise go to IDLE.
    - Back-to-back frames therefore have zero idle gap.
- Latency:
  - A word pushed into an empty FIFO while IDLE at edge N is popped at edge N+1.
  - txd falls after edge N+1, before any tick is needed.
  - START duration is counted from the first tick after entry.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE ticks.
- A tick arriving in IDLE is ignored.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
- Defaults, tick every clk, push 0x55 → txd 0 for 16 clk, then 1,0,1,0,1,0,1,0 at 16 clk each, then stop 1 for 16 clk. tx_done pulses once at clk 160 after start; busy drops the following cycle.
- PARITY = 2, DATA_BITS = 7, push 0x07 → parity bit 1, frame 160 ticks. PARITY = 1, push 0x03 → parity bit 1.
- Burst of 10 words with in_valid held high, frame in progress → 9 words accepted (one popped, 8 queued); in_ready = 0 and fifo_count = 8 until the next pop. The 10th word is accepted on the pop cycle + 1. All bytes are transmitted in order with no gap between stop and start.
- STOP_BITS = 2, tick every 4 clk → stop high for 128 clk; each data bit lasts 64 clk.
- Reset asserted mid-DATA with 3 words queued → txd = 1 and fifo_count = 0 asynchronously; after release, txd stays 1 and there is no tx_done.
- Push and pop on the same edge with FIFO at count 3 → count stays 3, and data order is preserved across pointer wrap (push 20 words in total).
